// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an asynchronous PWM input and
// converts them to an 8-bit duty code; flags stuck inputs via a rise timeout.
`timescale 1ns/1ps
module pwm_capture #(
  parameter int CLOCK_FREQUENCY    = 100_000_000,
  parameter int EXPECTED_FREQUENCY = 2_000,
  parameter int TIMEOUT_CYCLES     = 4 * CLOCK_FREQUENCY / EXPECTED_FREQUENCY,
  parameter int COUNT_WIDTH        = 20
) (
  input  logic                   i_fclk,
  input  logic                   i_reset_n,
  input  logic                   i_enable,
  input  logic                   i_pwm_in,
  output logic [COUNT_WIDTH-1:0] o_period_count,
  output logic [COUNT_WIDTH-1:0] o_high_count,
  output logic [7:0]             o_width,
  output logic                   o_valid,
  output logic                   o_stuck,
  output logic                   o_overrun
);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, MEASURE} state_t;

  localparam logic [COUNT_WIDTH-1:0] TO_LAST = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  state_t state, state_next;

  logic sync_a, sync_b, hist;
  logic rise, level;

  logic [COUNT_WIDTH-1:0] period_cnt, high_cnt, to_cnt;
  logic capture, timeout_hit;

  logic                   div_busy, div_sat;
  logic [3:0]             div_step;
  logic [COUNT_WIDTH-1:0] div_rem, div_period, div_high, rem_next;
  logic [7:0]             div_quot;
  logic [COUNT_WIDTH:0]   rem_shift;
  logic                   rem_fits;

  always_ff @(posedge i_fclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      hist   <= 1'b0;
    end else begin
      sync_a <= i_pwm_in;
      sync_b <= sync_a;
      hist   <= sync_b;
    end
  end

  assign rise  = sync_b & ~hist;
  assign level = sync_b;

  always_ff @(posedge i_fclk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_next;
  end

  // A rise in the same cycle as the timeout takes priority over the timeout.
  always_comb begin
    state_next  = state;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    if (!i_enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: state_next = WAIT_RISE;
        WAIT_RISE: begin
          if (rise)                     state_next = MEASURE;
          else if (to_cnt == TO_LAST)   timeout_hit = 1'b1;
        end
        MEASURE: begin
          if (rise) begin
            capture = 1'b1;
          end else if (to_cnt == TO_LAST) begin
            timeout_hit = 1'b1;
            state_next  = WAIT_RISE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_fclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      period_cnt <= '0;
      high_cnt   <= '0;
      to_cnt     <= '0;
    end else if (state == IDLE) begin
      period_cnt <= '0;
      high_cnt   <= '0;
      to_cnt     <= '0;
    end else if (rise) begin
      period_cnt <= CNT_ONE;
      high_cnt   <= CNT_ONE;
      to_cnt     <= '0;
    end else begin
      to_cnt <= timeout_hit ? '0 : to_cnt + CNT_ONE;
      if (state == MEASURE) begin
        if (period_cnt != '1)          period_cnt <= period_cnt + CNT_ONE;
        if (level && high_cnt != '1)   high_cnt   <= high_cnt + CNT_ONE;
      end
    end
  end

  // Remainder is kept below the divisor, so one extra bit covers the shift.
  always_comb begin
    rem_shift = {div_rem, 1'b0};
    rem_fits  = rem_shift >= {1'b0, div_period};
    rem_next  = rem_fits ? COUNT_WIDTH'(rem_shift - {1'b0, div_period})
                         : rem_shift[COUNT_WIDTH-1:0];
  end

  always_ff @(posedge i_fclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      div_busy       <= 1'b0;
      div_sat        <= 1'b0;
      div_step       <= '0;
      div_rem        <= '0;
      div_quot       <= '0;
      div_period     <= '0;
      div_high       <= '0;
      o_period_count <= '0;
      o_high_count   <= '0;
      o_width        <= '0;
      o_valid        <= 1'b0;
      o_stuck        <= 1'b0;
      o_overrun      <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (!i_enable) begin
        div_busy  <= 1'b0;
        o_stuck   <= 1'b0;
        o_overrun <= 1'b0;
      end else if (timeout_hit) begin
        div_busy       <= 1'b0;
        o_stuck        <= 1'b1;
        o_width        <= level ? 8'hFF : 8'h00;
        o_period_count <= '0;
        o_high_count   <= '0;
        o_valid        <= 1'b1;
      end else begin
        if (div_busy) begin
          if (div_sat || div_step == 4'd8) begin
            div_busy       <= 1'b0;
            o_width        <= div_sat ? 8'hFF : div_quot;
            o_period_count <= div_period;
            o_high_count   <= div_high;
            o_valid        <= 1'b1;
            o_stuck        <= 1'b0;
          end else begin
            div_rem  <= rem_next;
            div_quot <= {div_quot[6:0], rem_fits};
            div_step <= div_step + 4'd1;
          end
        end
        if (capture) begin
          if (div_busy) begin
            o_overrun <= 1'b1;
          end else begin
            div_busy   <= 1'b1;
            div_sat    <= high_cnt >= period_cnt;
            div_step   <= '0;
            div_rem    <= high_cnt;
            div_quot   <= '0;
            div_period <= period_cnt;
            div_high   <= high_cnt;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus predicts results from waveform
// parameters; a monitor pops expectations whenever o_valid is seen.
`timescale 1ns/1ps
module tb_pwm_capture;

  localparam int T  = 4000;
  localparam int CW = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          pwm = 1'b0;
  logic [CW-1:0] period_count, high_count;
  logic [7:0]    width;
  logic          valid, stuck, overrun;

  pwm_capture #(.TIMEOUT_CYCLES(T), .COUNT_WIDTH(CW)) dut (
    .i_fclk(clk), .i_reset_n(rst_n), .i_enable(enable), .i_pwm_in(pwm),
    .o_period_count(period_count), .o_high_count(high_count), .o_width(width),
    .o_valid(valid), .o_stuck(stuck), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc; int period; int high; int width; bit stuck; bit ovr;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   pq[$];
  int   hq[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_valid: got o_valid=1 at cycle %0d, expected none", cyc);
      end else begin
        mon_e = sbq.pop_front();
        check("valid_cycle", cyc, mon_e.cyc);
        check("period", period_count, mon_e.period);
        check("high", high_count, mon_e.high);
        check("width", width, mon_e.width);
        check("stuck", stuck, mon_e.stuck);
        check("overrun", overrun, mon_e.ovr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    tick();
    tick();
    check("drain_empty", sbq.size(), 0);
  endtask

  task automatic push_exp(input int c, input int p, input int h, input int w,
                          input bit s, input bit o);
    exp_t e;
    e.cyc = c; e.period = p; e.high = h; e.width = w; e.stuck = s; e.ovr = o;
    sbq.push_back(e);
  endtask

  // Rise k (k>=1) after the first one reports period k-1. A capture reaches the
  // divider 3 cycles after the pin rises; the divider is occupied for 9 cycles
  // (1 if high >= period) and refuses captures until its result is out.
  task automatic run_train(input int n, input bit expect_last, output int close_cyc);
    int tc, ct, l, last_free, pub;
    int acc_k[$], acc_t[$], acc_l[$], drops[$];
    bit ov;
    longint w;
    tc = cyc;
    last_free = -1;
    for (int k = 1; k <= n; k++) begin
      tc += pq[k-1];
      ct = tc + 3;
      l  = (hq[k-1] >= pq[k-1]) ? 1 : 9;
      if (ct > last_free) begin
        acc_k.push_back(k); acc_t.push_back(ct); acc_l.push_back(l);
        last_free = ct + l;
      end else begin
        drops.push_back(ct);
      end
    end
    for (int i = 0; i < acc_k.size(); i++) begin
      if (acc_k[i] < n || expect_last) begin
        pub = acc_t[i] + acc_l[i];
        ov = 1'b0;
        foreach (drops[j]) if (drops[j] <= pub) ov = 1'b1;
        w = (longint'(hq[acc_k[i]-1]) * 256) / pq[acc_k[i]-1];
        if (w > 255) w = 255;
        push_exp(pub, pq[acc_k[i]-1], hq[acc_k[i]-1], int'(w), 1'b0, ov);
      end
    end
    for (int i = 0; i < n; i++) begin
      pwm = 1'b1;
      repeat (hq[i]) tick();
      pwm = 1'b0;
      repeat (pq[i] - hq[i]) tick();
    end
    pwm = 1'b1;
    close_cyc = cyc;
  endtask

  task automatic go_idle();
    enable = 1'b0;
    pwm = 1'b0;
    repeat (5) tick();
  endtask

  task automatic start();
    enable = 1'b1;
    repeat (5) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int dc, e, p;
    repeat (3) tick();
    check("reset_period", period_count, 0);
    check("reset_high", high_count, 0);
    check("reset_width", width, 0);
    check("reset_valid", valid, 0);
    check("reset_stuck", stuck, 0);
    check("reset_overrun", overrun, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Nominal and boundary duty ratios
    start();
    pq = {1000, 1000, 1000, 3000, 1000};
    hq = {250, 250, 250, 1500, 999};
    run_train(5, 1'b1, dc);
    drain(100);
    go_idle();
    check("disable_width_hold", width, 255);
    check("disable_stuck", stuck, 0);

    // Randomized trains, small periods exercise dropped captures
    for (int r = 0; r < 4; r++) begin
      start();
      pq = {}; hq = {};
      for (int i = 0; i < 4; i++) begin
        p = $urandom_range(1200, 8);
        pq.push_back(p);
        hq.push_back($urandom_range(p - 1, 1));
      end
      run_train(4, 1'b1, dc);
      drain(100);
      go_idle();
    end

    // Divider overrun at period 5
    start();
    pq = {5, 5, 5, 5};
    hq = {2, 2, 2, 2};
    run_train(4, 1'b1, dc);
    drain(100);
    check("overrun_sticky", overrun, 1);
    go_idle();
    check("overrun_cleared", overrun, 0);

    // Stuck high, then recovery
    pwm = 1'b1;
    repeat (10) tick();
    enable = 1'b1;
    e = cyc;
    push_exp(e + T + 1, 0, 0, 255, 1'b1, 1'b0);
    push_exp(e + 2 * T + 1, 0, 0, 255, 1'b1, 1'b0);
    wait_until(e + 2 * T + 3);
    check("stuck_high_flag", stuck, 1);
    pwm = 1'b0;
    repeat (500) tick();
    pq = {1000};
    hq = {500};
    run_train(1, 1'b1, dc);
    drain(100);
    check("stuck_recovered", stuck, 0);
    go_idle();

    // Stuck low, then disable
    enable = 1'b1;
    e = cyc;
    push_exp(e + T + 1, 0, 0, 0, 1'b1, 1'b0);
    wait_until(e + T + 5);
    drain(10);
    check("stuck_low_flag", stuck, 1);
    enable = 1'b0;
    repeat (2) tick();
    check("stuck_low_disable_stuck", stuck, 0);
    check("stuck_low_disable_width", width, 0);

    // Disable while the divider is busy
    start();
    pq = {1000, 1000};
    hq = {250, 250};
    run_train(2, 1'b0, dc);
    repeat (6) tick();
    enable = 1'b0;
    pwm = 1'b0;
    repeat (20) tick();
    check("abort_width_hold", width, 64);
    check("abort_no_pending", sbq.size(), 0);

    // Reset while the divider is busy
    start();
    run_train(2, 1'b0, dc);
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    check("midreset_period", period_count, 0);
    check("midreset_high", high_count, 0);
    check("midreset_width", width, 0);
    check("midreset_valid", valid, 0);
    check("midreset_stuck", stuck, 0);
    check("midreset_overrun", overrun, 0);
    repeat (3) tick();
    enable = 1'b0;
    pwm = 1'b0;
    rst_n = 1'b1;
    repeat (20) tick();
    check("final_queue_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
